dsp_add_v3_pack: RTL and testbench

- Upstream feeder for the three-lane 12-bit SIMD DSP adder.
- Accepts a stream of scalar add requests (a, b) over a valid/ready handshake and packs three consecutive requests into lanes 0..2.
- Presents each packed group as a registered, stable operand set (a0/b0..a2/b2) with its own valid/ready handshake and a lane-valid mask, so the adder's outputs can be unpacked downstream.
- Partial groups can be issued early with a flush request.

---
 rtl/dsp_add_v3_pack.sv | 190 +++++++++++++++++++
 tb/tb_dsp_add_v3_pack.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_add_v3_pack.sv
// Packs a scalar (a, b) request stream into registered three-lane operand groups.
// Define DSP_PACK_TIMEOUT_EN to build the idle counter that auto-flushes partial groups.
module dsp_add_v3_pack #(
   parameter int WIDTH   = 12,
   parameter int TIMEOUT = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_a0_o,
   output logic [WIDTH-1:0] out_b0_o,
   output logic [WIDTH-1:0] out_a1_o,
   output logic [WIDTH-1:0] out_b1_o,
   output logic [WIDTH-1:0] out_a2_o,
   output logic [WIDTH-1:0] out_b2_o,
   output logic [2:0]       out_mask_o,
   output logic [7:0]       out_seq_o
);

   if (WIDTH < 1 || WIDTH > 12) begin : g_bad_width
      $error("dsp_add_v3_pack: WIDTH must be in 1..12");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("dsp_add_v3_pack: TIMEOUT must be in 1..255");
   end

   logic [1:0]            cnt_q, cnt_d;
   logic [1:0][WIDTH-1:0] col_a_q, col_b_q;
   logic                  flush_pend_q, flush_pend_d;

   logic                  out_valid_q, out_valid_d;
   logic [2:0][WIDTH-1:0] out_a_q, out_b_q;
   logic [2:0]            out_mask_q, out_mask_d;
   logic [7:0]            out_seq_q, out_seq_d;

   logic                  avail;
   logic                  accept;
   logic                  flush_req;
   logic                  launch;
   logic [1:0]            fill;
   logic [2:0][WIDTH-1:0] lane_a, lane_b;
   logic                  timeout_hit;

   assign avail      = !out_valid_q || out_ready_i;
   assign in_ready_o = rst_ni && ((cnt_q != 2'd2) || avail);
   assign accept     = in_valid_i && in_ready_o;
   assign flush_req  = flush_pend_q || flush_i;
   assign fill       = cnt_q + {1'b0, accept};

   assign launch = avail && ((accept && (cnt_q == 2'd2)) ||
                             (flush_req && (fill != 2'd0)));

   // Launch view of the lanes: collected lanes first, a same-cycle accept lands at lane cnt_q.
   always_comb begin
      lane_a = '0;
      lane_b = '0;
      if (cnt_q != 2'd0) begin
         lane_a[0] = col_a_q[0];
         lane_b[0] = col_b_q[0];
      end else if (accept) begin
         lane_a[0] = in_a_i;
         lane_b[0] = in_b_i;
      end
      if (cnt_q == 2'd2) begin
         lane_a[1] = col_a_q[1];
         lane_b[1] = col_b_q[1];
      end else if (cnt_q == 2'd1 && accept) begin
         lane_a[1] = in_a_i;
         lane_b[1] = in_b_i;
      end
      if (cnt_q == 2'd2 && accept) begin
         lane_a[2] = in_a_i;
         lane_b[2] = in_b_i;
      end
   end

`ifdef DSP_PACK_TIMEOUT_EN
   logic [7:0] idle_q, idle_d;

   always_comb begin
      idle_d = idle_q;
      if (accept || launch) begin
         idle_d = 8'd0;
      end else if (cnt_q != 2'd0 && idle_q != 8'hFF) begin
         idle_d = idle_q + 8'd1;
      end
   end

   assign timeout_hit = (idle_d == 8'(TIMEOUT));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idle_q <= 8'd0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q;
      if (launch) begin
         cnt_d        = 2'd0;
         flush_pend_d = 1'b0;
      end else begin
         if (accept) begin
            cnt_d = cnt_q + 2'd1;
         end
         // An empty collector never yields a group, so a flush there is simply dropped.
         if (fill == 2'd0) begin
            flush_pend_d = 1'b0;
         end else if (flush_i || timeout_hit) begin
            flush_pend_d = 1'b1;
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_mask_d  = out_mask_q;
      out_seq_d   = out_seq_q;
      if (launch) begin
         out_valid_d = 1'b1;
         out_seq_d   = out_seq_q + 8'd1;
         unique case (fill)
            2'd1:    out_mask_d = 3'b001;
            2'd2:    out_mask_d = 3'b011;
            2'd3:    out_mask_d = 3'b111;
            default: out_mask_d = 3'b000;
         endcase
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q        <= 2'd0;
         flush_pend_q <= 1'b0;
         col_a_q      <= '0;
         col_b_q      <= '0;
      end else begin
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         // Without a launch an accept always finds cnt_q < 2.
         if (accept && !launch) begin
            col_a_q[cnt_q[0]] <= in_a_i;
            col_b_q[cnt_q[0]] <= in_b_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         out_mask_q  <= 3'b000;
         out_seq_q   <= 8'd0;
         out_a_q     <= '0;
         out_b_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_mask_q  <= out_mask_d;
         out_seq_q   <= out_seq_d;
         if (launch) begin
            out_a_q <= lane_a;
            out_b_q <= lane_b;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_mask_o  = out_mask_q;
   assign out_seq_o   = out_seq_q;
   assign out_a0_o    = out_a_q[0];
   assign out_b0_o    = out_b_q[0];
   assign out_a1_o    = out_a_q[1];
   assign out_b1_o    = out_b_q[1];
   assign out_a2_o    = out_a_q[2];
   assign out_b2_o    = out_b_q[2];

endmodule

// File: tb/tb_dsp_add_v3_pack.sv
// Bench for dsp_add_v3_pack: directed scenarios plus randomized traffic against a queue-based model.
module tb_dsp_add_v3_pack;
   localparam int W  = 12;
   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic         flush = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] oa0, ob0, oa1, ob1, oa2, ob2;
   logic [2:0]   out_mask;
   logic [7:0]   out_seq;

   int total = 0;
   int bad   = 0;

   dsp_add_v3_pack #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_a_i(in_a), .in_b_i(in_b), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_a0_o(oa0), .out_b0_o(ob0), .out_a1_o(oa1), .out_b1_o(ob1),
      .out_a2_o(oa2), .out_b2_o(ob2),
      .out_mask_o(out_mask), .out_seq_o(out_seq)
   );

   always #5 clk = ~clk;

   // Reference model: pending requests in a queue, output slot as plain variables.
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } pair_t;

   pair_t        m_coll[$];
   bit           m_fp;
   bit           m_ov;
   logic [W-1:0] m_a[3];
   logic [W-1:0] m_b[3];
   logic [2:0]   m_mask;
   logic [7:0]   m_seq;
   int           m_idle;
   bit           m_launched;

   function automatic bit m_ready();
      return rst_n && (m_coll.size() < 2 || !m_ov || out_ready);
   endfunction

   task automatic model_reset();
      m_coll.delete();
      m_fp = 0; m_ov = 0; m_mask = 3'b000; m_seq = 8'd0; m_idle = 0;
      for (int i = 0; i < 3; i++) begin
         m_a[i] = '0;
         m_b[i] = '0;
      end
   endtask

   task automatic model_step();
      bit avail, acc, launch, tmo;
      int n;
      avail  = !m_ov || out_ready;
      acc    = in_valid && m_ready();
      n      = m_coll.size() + (acc ? 1 : 0);
      launch = avail && ((acc && m_coll.size() == 2) || ((m_fp || flush) && n > 0));
      if (acc) m_coll.push_back('{a: in_a, b: in_b});
      if (acc || launch) m_idle = 0;
      else if (m_coll.size() > 0 && m_idle < 255) m_idle++;
      tmo = 0;
`ifdef DSP_PACK_TIMEOUT_EN
      if (m_idle == TO) tmo = 1;
`endif
      m_launched = launch;
      if (launch) begin
         for (int i = 0; i < 3; i++) begin
            m_a[i] = (i < n) ? m_coll[i].a : '0;
            m_b[i] = (i < n) ? m_coll[i].b : '0;
         end
         m_mask = 3'((1 << n) - 1);
         m_ov   = 1;
         m_seq  = m_seq + 8'd1;
         m_coll.delete();
         m_fp   = 0;
      end else begin
         if (out_ready) m_ov = 0;
         if (n == 0) m_fp = 0;
         else if (flush || tmo) m_fp = 1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      if (m_launched)
         $display("group seq=%0d mask=%b a=%0h/%0h/%0h b=%0h/%0h/%0h",
                  m_seq, m_mask, m_a[0], m_a[1], m_a[2], m_b[0], m_b[1], m_b[2]);
   endtask

   task automatic drive(input bit v, input int a, input int b, input bit f, input bit r);
      in_valid  = v;
      in_a      = W'(a);
      in_b      = W'(b);
      flush     = f;
      out_ready = r;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++;
      if (out_mask !== 3'b000 || out_seq !== 8'd0) begin
         bad++; $display("FAIL reset_mask_seq: got %b/%0d want 000/0", out_mask, out_seq);
      end
      total++;
      if ({oa0, ob0, oa1, ob1, oa2, ob2} !== '0) begin bad++; $display("FAIL reset_data: not zero"); end
      drive(1, 1, 2, 0, 1);
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      drive(0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_full_group();
      drive(1, 1, 2, 0, 1);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL full_in_ready: got %b want 1", in_ready); end
      tick();
      drive(1, 3, 4, 0, 1); tick();
      drive(1, 5, 6, 0, 1); tick();
      drive(0, 0, 0, 0, 0);
      total++;
      if (out_valid !== 1'b1 || out_mask !== 3'b111 || out_seq !== 8'd1) begin
         bad++; $display("FAIL full_ctrl: got v=%b m=%b s=%0d want 1/111/1", out_valid, out_mask, out_seq);
      end
      total++;
      if ({oa0, ob0, oa1, ob1, oa2, ob2} !== {12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6}) begin
         bad++; $display("FAIL full_data: got %0d/%0d %0d/%0d %0d/%0d want 1/2 3/4 5/6", oa0, ob0, oa1, ob1, oa2, ob2);
      end
   endtask

   task automatic test_backpressure();
      drive(1, 20, 21, 0, 0); tick();
      drive(1, 22, 23, 0, 0); tick();
      drive(1, 24, 25, 0, 0);
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_seq !== 8'd1 || oa0 !== 12'd1 || ob2 !== 12'd6) begin
         bad++; $display("FAIL bp_stable: got v=%b s=%0d a0=%0d b2=%0d want 1/1/1/6", out_valid, out_seq, oa0, ob2);
      end
      drive(1, 24, 25, 0, 1);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_high: got %b want 1", in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_seq !== 8'd2 || out_mask !== 3'b111) begin
         bad++; $display("FAIL bp_group2_ctrl: got v=%b s=%0d m=%b want 1/2/111", out_valid, out_seq, out_mask);
      end
      total++;
      if ({oa0, ob0, oa1, ob1, oa2, ob2} !== {12'd20, 12'd21, 12'd22, 12'd23, 12'd24, 12'd25}) begin
         bad++; $display("FAIL bp_group2_data: got %0d/%0d %0d/%0d %0d/%0d", oa0, ob0, oa1, ob1, oa2, ob2);
      end
      drive(0, 0, 0, 0, 1); tick();
      total++;
      if (out_valid !== 1'b0 || oa0 !== 12'd20) begin
         bad++; $display("FAIL bp_clear: got v=%b a0=%0d want 0/20", out_valid, oa0);
      end
   endtask

   task automatic test_flush();
      drive(1, 7, 8, 0, 1); tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_early: got v=%b want 0", out_valid); end
      drive(0, 0, 0, 1, 1); tick();
      total++;
      if (out_valid !== 1'b1 || out_mask !== 3'b001 || out_seq !== 8'd3) begin
         bad++; $display("FAIL flush_ctrl: got v=%b m=%b s=%0d want 1/001/3", out_valid, out_mask, out_seq);
      end
      total++;
      if ({oa0, ob0, oa1, ob1, oa2, ob2} !== {12'd7, 12'd8, 48'd0}) begin
         bad++; $display("FAIL flush_data: got %0d/%0d %0d/%0d %0d/%0d want 7/8 0/0 0/0", oa0, ob0, oa1, ob1, oa2, ob2);
      end
      drive(0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 1, 1); tick();
      drive(0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty: cycle %0d got v=%b want 0", k, out_valid); end
         tick();
      end
   endtask

   task automatic test_flush_accept();
      drive(1, 9, 10, 0, 1); tick();
      drive(1, 11, 12, 1, 1); tick();
      total++;
      if (out_valid !== 1'b1 || out_mask !== 3'b011 || out_seq !== 8'd4) begin
         bad++; $display("FAIL fa_ctrl: got v=%b m=%b s=%0d want 1/011/4", out_valid, out_mask, out_seq);
      end
      total++;
      if ({oa0, ob0, oa1, ob1, oa2, ob2} !== {12'd9, 12'd10, 12'd11, 12'd12, 24'd0}) begin
         bad++; $display("FAIL fa_data: got %0d/%0d %0d/%0d %0d/%0d", oa0, ob0, oa1, ob1, oa2, ob2);
      end
      drive(1, 13, 14, 0, 0); tick();
      drive(0, 0, 0, 1, 0); tick();
      drive(0, 0, 0, 0, 0); tick(); tick();
      total++;
      if (out_valid !== 1'b1 || out_seq !== 8'd4 || out_mask !== 3'b011) begin
         bad++; $display("FAIL fa_blocked_hold: got v=%b s=%0d m=%b want 1/4/011", out_valid, out_seq, out_mask);
      end
      drive(0, 0, 0, 0, 1); tick();
      total++;
      if (out_valid !== 1'b1 || out_seq !== 8'd5 || out_mask !== 3'b001 || oa0 !== 12'd13 || ob0 !== 12'd14) begin
         bad++; $display("FAIL fa_sticky: got v=%b s=%0d m=%b a0=%0d b0=%0d want 1/5/001/13/14",
                         out_valid, out_seq, out_mask, oa0, ob0);
      end
      drive(0, 0, 0, 0, 1); tick();
   endtask

   task automatic test_reset_mid();
      drive(1, 30, 31, 0, 1); tick();
      drive(1, 32, 33, 0, 1); tick();
      drive(1, 34, 35, 0, 1); tick();
      drive(1, 40, 41, 0, 0); tick();
      drive(1, 42, 43, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_mask !== 3'b000 || out_seq !== 8'd0) begin
         bad++; $display("FAIL rstmid_async: got v=%b m=%b s=%0d want 0/000/0", out_valid, out_mask, out_seq);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1, 50, 51, 0, 1); tick();
      drive(1, 52, 53, 0, 1); tick();
      drive(1, 54, 55, 0, 1); tick();
      drive(0, 0, 0, 0, 1);
      total++;
      if (out_valid !== 1'b1 || out_seq !== 8'd1 || out_mask !== 3'b111 ||
          {oa0, ob0, oa1, ob1, oa2, ob2} !== {12'd50, 12'd51, 12'd52, 12'd53, 12'd54, 12'd55}) begin
         bad++; $display("FAIL rstmid_fresh: got v=%b s=%0d m=%b a=%0d/%0d/%0d", out_valid, out_seq, out_mask, oa0, oa1, oa2);
      end
      tick();
   endtask

   task automatic test_timeout();
      drive(1, 60, 61, 0, 1); tick();
      drive(0, 0, 0, 0, 1);
`ifdef DSP_PACK_TIMEOUT_EN
      begin
         int seen;
         seen = -1;
         for (int k = 1; k <= 20 && seen < 0; k++) begin
            tick();
            if (out_valid === 1'b1) seen = k;
         end
         total++;
         if (seen != TO + 1 || out_mask !== 3'b001 || oa0 !== 12'd60) begin
            bad++; $display("FAIL timeout_issue: got cycle %0d m=%b a0=%0d want %0d/001/60", seen, out_mask, oa0, TO + 1);
         end
      end
`else
      for (int k = 0; k < 100; k++) begin
         tick();
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL no_timeout: cycle %0d got v=%b want 0", k, out_valid); end
      end
      drive(0, 0, 0, 1, 1); tick();
      total++;
      if (out_valid !== 1'b1 || out_mask !== 3'b001 || oa0 !== 12'd60) begin
         bad++; $display("FAIL no_timeout_flush: got v=%b m=%b a0=%0d want 1/001/60", out_valid, out_mask, oa0);
      end
`endif
      drive(0, 0, 0, 0, 1); tick();
   endtask

   task automatic test_back_to_back();
      // Continuous traffic with a free consumer: a group every third cycle, enough to wrap out_seq.
      for (int k = 0; k < 800; k++) begin
         drive(1, $urandom_range(0, 4095), $urandom_range(0, 4095), 0, 1);
         tick();
         total++;
         if (out_valid !== m_ov || out_seq !== m_seq) begin
            bad++; $display("FAIL b2b_cycle%0d: got v=%b s=%0d want %b/%0d", k, out_valid, out_seq, m_ov, m_seq);
         end
      end
      drive(0, 0, 0, 1, 1); tick();
      drive(0, 0, 0, 0, 1); tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 4095), $urandom_range(0, 4095),
               $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6);
         #1;
         total++;
         if (in_ready !== m_ready()) begin
            bad++; $display("FAIL rand_in_ready%0d: got %b want %b", k, in_ready, m_ready());
         end
         tick();
         total++;
         if (out_valid !== m_ov || out_mask !== m_mask || out_seq !== m_seq ||
             {oa0, oa1, oa2} !== {m_a[0], m_a[1], m_a[2]} ||
             {ob0, ob1, ob2} !== {m_b[0], m_b[1], m_b[2]}) begin
            bad++;
            $display("FAIL rand_out%0d: got v=%b m=%b s=%0d a=%0h/%0h/%0h b=%0h/%0h/%0h want v=%b m=%b s=%0d a=%0h/%0h/%0h b=%0h/%0h/%0h",
                     k, out_valid, out_mask, out_seq, oa0, oa1, oa2, ob0, ob1, ob2,
                     m_ov, m_mask, m_seq, m_a[0], m_a[1], m_a[2], m_b[0], m_b[1], m_b[2]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_group();
      test_backpressure();
      test_flush();
      test_flush_accept();
      test_reset_mid();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
